// File: rtl/qerv_rf_ram_pkg.sv
`default_nettype none
// ============================================================================
// Module      : qerv_rf_ram_pkg
// Description : Shared definitions for the RAM-backed register file
//               controller: CSR register indices and read FSM states.
// Revision    : 1.0 - initial release
// ============================================================================
package qerv_rf_ram_pkg;

    // CSRs live just above the 32 GPRs in the RAM register map
    localparam logic [5:0] c_mscratch = 6'd32;
    localparam logic [5:0] c_mtvec    = 6'd33;
    localparam logic [5:0] c_mepc     = 6'd34;
    localparam logic [5:0] c_mtval    = 6'd35;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_PRIME0 = 2'd1,
        ST_PRIME1 = 2'd2,
        ST_RUN    = 2'd3
    } rd_state_t;

endpackage
`default_nettype wire

// File: rtl/qerv_rf_ram_wbuf.sv
`default_nettype none
// ============================================================================
// Module      : qerv_rf_ram_wbuf
// Description : Per-port write chunk accumulator. Collects R serial chunks
//               (LSB first) into one RAM word and copies it to a holding
//               register, flagging it valid for one cycle if the port wrote.
// Revision    : 1.0 - initial release
// ============================================================================
module qerv_rf_ram_wbuf #(
    parameter int W     = 1,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             i_rst,
    input  logic             i_adv,
    input  logic             i_last,
    input  logic             i_wen,
    input  logic [W-1:0]     i_wdata,
    output logic [WIDTH-1:0] o_word,
    output logic             o_valid
);

    logic [WIDTH-W-1:0] r_buf;
    logic [WIDTH-1:0]   r_hold;
    logic [WIDTH-1:0]   w_next;
    logic               r_any;
    logic               r_hv;

    // New chunk enters at the top so the first chunk ends up at bit 0
    assign w_next = {i_wdata, r_buf};

    // Data path: shift chunks in, capture the full word on the last chunk
    always_ff @(posedge clk) begin
        if (i_adv) begin
            r_buf <= w_next[WIDTH-1:W];
            if (i_last) begin
                r_hold <= w_next;
            end
        end
    end

    // Track whether this port strobed during the word; pulse valid once
    always_ff @(posedge clk or posedge i_rst) begin
        if (i_rst) begin
            r_any <= 1'b0;
            r_hv  <= 1'b0;
        end else begin
            r_hv <= i_adv && i_last && (r_any || i_wen);
            if (i_adv) begin
                r_any <= i_last ? 1'b0 : (r_any || i_wen);
            end
        end
    end

    assign o_word  = r_hold;
    assign o_valid = r_hv;

endmodule
`default_nettype wire

// File: rtl/qerv_rf_ram_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : qerv_rf_ram_ctrl
// Description : Serialising register-file front end for a single-port-pair
//               RAM. Reads two registers as gap-free W-bit streams and
//               assembles two serial write streams into RAM words.
// Revision    : 1.0 - initial release
// ============================================================================
module qerv_rf_ram_ctrl
    import qerv_rf_ram_pkg::*;
#(
    parameter int W        = 1,
    parameter int WIDTH    = 8,
    parameter int WITH_CSR = 1,
    localparam int R       = WIDTH / W,
    localparam int NW      = 32 / WIDTH,
    localparam int DEPTH   = (32 + 4 * WITH_CSR) * NW,
    localparam int AW      = $clog2(DEPTH),
    localparam int RW      = 5 + WITH_CSR
) (
    input  logic             clk,
    input  logic             i_rst,
    input  logic             i_rreq,
    output logic             o_ready,
    input  logic [RW-1:0]    i_rreg0,
    input  logic [RW-1:0]    i_rreg1,
    output logic [W-1:0]     o_rdata0,
    output logic [W-1:0]     o_rdata1,
    input  logic [RW-1:0]    i_wreg0,
    input  logic [RW-1:0]    i_wreg1,
    input  logic             i_wen0,
    input  logic             i_wen1,
    input  logic [W-1:0]     i_wdata0,
    input  logic [W-1:0]     i_wdata1,
    output logic [AW-1:0]    o_waddr,
    output logic [WIDTH-1:0] o_wdata,
    output logic             o_wen,
    output logic [AW-1:0]    o_raddr,
    output logic             o_ren,
    input  logic [WIDTH-1:0] i_rdata
);

    localparam int NCH = 32 / W;
    localparam int CW  = $clog2(NCH);
    localparam int LR  = $clog2(R);

    function automatic logic [AW-1:0] f_addr(input logic [RW-1:0] rnum,
                                             input logic [CW-1:0] word);
        return AW'(rnum) * AW'(NW) + AW'(word);
    endfunction

    // ------------------------------------------------------------------
    // Read side
    // ------------------------------------------------------------------
    rd_state_t          r_state;
    rd_state_t          w_state_nxt;
    logic [CW-1:0]      r_rcnt;
    logic [CW-1:0]      w_rp;
    logic [CW-1:0]      w_rk;
    logic               w_rlast;
    logic               w_rmore;
    logic               w_bypass;
    logic [RW-1:0]      r_rreg0;
    logic [RW-1:0]      r_rreg1;
    logic [WIDTH-1:0]   r_sh0;
    logic [WIDTH-1:0]   r_sh1;
    logic [WIDTH-1:0]   r_pre0;
    logic [WIDTH-1:0]   w_word0;
    logic [WIDTH-1:0]   w_word1;

    assign w_rp    = r_rcnt & CW'(R - 1);
    assign w_rk    = r_rcnt >> LR;
    assign w_rlast = (r_rcnt == CW'(NCH - 1));
    assign w_rmore = (w_rk < CW'(NW - 1));

    // At the first chunk of every later word the fresh words are consumed
    // directly (rreg1 straight off the RAM bus) so output never stalls
    assign w_bypass = (r_state == ST_RUN) && (w_rp == '0) && (w_rk != '0);
    assign w_word0  = w_bypass ? r_pre0  : r_sh0;
    assign w_word1  = w_bypass ? i_rdata : r_sh1;

    assign o_rdata0 = (r_state == ST_RUN && r_rreg0 != '0) ? w_word0[W-1:0] : '0;
    assign o_rdata1 = (r_state == ST_RUN && r_rreg1 != '0) ? w_word1[W-1:0] : '0;

    // Read FSM state register
    always_ff @(posedge clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Read FSM next state plus RAM read requests and ready pulse
    always_comb begin
        w_state_nxt = r_state;
        o_ready     = 1'b0;
        o_ren       = 1'b0;
        o_raddr     = '0;
        case (r_state)
            ST_IDLE: begin
                if (i_rreq && !i_rst) begin
                    w_state_nxt = ST_PRIME0;
                    o_ren       = 1'b1;
                    o_raddr     = f_addr(i_rreg0, '0);
                end
            end
            ST_PRIME0: begin
                w_state_nxt = ST_PRIME1;
                o_ren       = 1'b1;
                o_raddr     = f_addr(r_rreg1, '0);
            end
            ST_PRIME1: begin
                w_state_nxt = ST_RUN;
                o_ready     = 1'b1;
            end
            ST_RUN: begin
                if (w_rlast) begin
                    w_state_nxt = ST_IDLE;
                end
                if (w_rmore && w_rp == CW'(R - 2)) begin
                    o_ren   = 1'b1;
                    o_raddr = f_addr(r_rreg0, w_rk + CW'(1));
                end else if (w_rmore && w_rp == CW'(R - 1)) begin
                    o_ren   = 1'b1;
                    o_raddr = f_addr(r_rreg1, w_rk + CW'(1));
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Read chunk counter, running only while streaming
    always_ff @(posedge clk or posedge i_rst) begin
        if (i_rst) begin
            r_rcnt <= '0;
        end else if (r_state == ST_RUN && !w_rlast) begin
            r_rcnt <= r_rcnt + CW'(1);
        end else begin
            r_rcnt <= '0;
        end
    end

    // Latch the register pair when a read is accepted
    always_ff @(posedge clk) begin
        if (r_state == ST_IDLE && i_rreq) begin
            r_rreg0 <= i_rreg0;
            r_rreg1 <= i_rreg1;
        end
    end

    // Read shift registers and the rreg0 prefetch buffer
    always_ff @(posedge clk) begin
        case (r_state)
            ST_PRIME0: r_sh0 <= i_rdata;
            ST_PRIME1: r_sh1 <= i_rdata;
            ST_RUN: begin
                r_sh0 <= w_word0 >> W;
                r_sh1 <= w_word1 >> W;
                if (w_rmore && w_rp == CW'(R - 1)) begin
                    r_pre0 <= i_rdata;
                end
            end
            default: ;
        endcase
    end

    // ------------------------------------------------------------------
    // Write side
    // ------------------------------------------------------------------
    logic               w_wadv;
    logic [CW-1:0]      r_wcnt;
    logic [CW-1:0]      w_wp;
    logic [CW-1:0]      w_wk;
    logic               w_wlast;
    logic [CW-1:0]      r_wword;
    logic [RW-1:0]      r_wreg0;
    logic [RW-1:0]      r_wreg1;
    logic [WIDTH-1:0]   w_hold0;
    logic [WIDTH-1:0]   w_hold1;
    logic               w_hv0;
    logic               w_hv1;
    logic               r_p1_valid;
    logic [AW-1:0]      r_p1_addr;

    assign w_wadv  = i_wen0 | i_wen1;
    assign w_wp    = r_wcnt & CW'(R - 1);
    assign w_wk    = r_wcnt >> LR;
    assign w_wlast = (w_wp == CW'(R - 1));

    // Shared write chunk counter and index of the word just completed
    always_ff @(posedge clk or posedge i_rst) begin
        if (i_rst) begin
            r_wcnt  <= '0;
            r_wword <= '0;
        end else if (w_wadv) begin
            r_wcnt <= (r_wcnt == CW'(NCH - 1)) ? '0 : r_wcnt + CW'(1);
            if (w_wlast) begin
                r_wword <= w_wk;
            end
        end
    end

    // Write register addresses are taken with the first chunk
    always_ff @(posedge clk) begin
        if (w_wadv && r_wcnt == '0) begin
            r_wreg0 <= i_wreg0;
            r_wreg1 <= i_wreg1;
        end
    end

    qerv_rf_ram_wbuf #(.W(W), .WIDTH(WIDTH)) u_wbuf0 (
        .clk     (clk),
        .i_rst   (i_rst),
        .i_adv   (w_wadv),
        .i_last  (w_wlast),
        .i_wen   (i_wen0),
        .i_wdata (i_wdata0),
        .o_word  (w_hold0),
        .o_valid (w_hv0)
    );

    qerv_rf_ram_wbuf #(.W(W), .WIDTH(WIDTH)) u_wbuf1 (
        .clk     (clk),
        .i_rst   (i_rst),
        .i_adv   (w_wadv),
        .i_last  (w_wlast),
        .i_wen   (i_wen1),
        .i_wdata (i_wdata1),
        .o_word  (w_hold1),
        .o_valid (w_hv1)
    );

    // Port 1 waits one cycle behind port 0; its address is frozen now in
    // case a new write already updates the register latches next cycle
    always_ff @(posedge clk or posedge i_rst) begin
        if (i_rst) begin
            r_p1_valid <= 1'b0;
            r_p1_addr  <= '0;
        end else begin
            r_p1_valid <= w_hv1;
            r_p1_addr  <= f_addr(r_wreg1, r_wword);
        end
    end

    assign o_wen   = w_hv0 | r_p1_valid;
    assign o_waddr = w_hv0 ? f_addr(r_wreg0, r_wword) : (r_p1_valid ? r_p1_addr : '0);
    assign o_wdata = w_hv0 ? w_hold0 : w_hold1;

endmodule
`default_nettype wire

// File: tb/tb_qerv_rf_ram_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_qerv_rf_ram_ctrl
// Description : Self-checking bench for qerv_rf_ram_ctrl (W=1, WIDTH=8,
//               WITH_CSR=1) with a behavioural RAM and write/read scoreboards.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_qerv_rf_ram_ctrl;

    logic       clk;
    logic       i_rst;
    logic       i_rreq;
    logic       o_ready;
    logic [5:0] i_rreg0, i_rreg1;
    logic       o_rdata0, o_rdata1;
    logic [5:0] i_wreg0, i_wreg1;
    logic       i_wen0, i_wen1;
    logic       i_wdata0, i_wdata1;
    logic [7:0] o_waddr;
    logic [7:0] o_wdata;
    logic       o_wen;
    logic [7:0] o_raddr;
    logic       o_ren;
    logic [7:0] i_rdata;

    int checks   = 0;
    int failures = 0;

    logic [7:0]  mem [0:143];
    logic [15:0] wq [$];
    logic [63:0] rq [$];
    logic [15:0] wexp;

    qerv_rf_ram_ctrl #(.W(1), .WIDTH(8), .WITH_CSR(1)) dut (
        .clk      (clk),
        .i_rst    (i_rst),
        .i_rreq   (i_rreq),
        .o_ready  (o_ready),
        .i_rreg0  (i_rreg0),
        .i_rreg1  (i_rreg1),
        .o_rdata0 (o_rdata0),
        .o_rdata1 (o_rdata1),
        .i_wreg0  (i_wreg0),
        .i_wreg1  (i_wreg1),
        .i_wen0   (i_wen0),
        .i_wen1   (i_wen1),
        .i_wdata0 (i_wdata0),
        .i_wdata1 (i_wdata1),
        .o_waddr  (o_waddr),
        .o_wdata  (o_wdata),
        .o_wen    (o_wen),
        .o_raddr  (o_raddr),
        .o_ren    (o_ren),
        .i_rdata  (i_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural RAM: one-cycle read latency
    always @(posedge clk) begin
        if (o_wen) mem[o_waddr] <= o_wdata;
        if (o_ren) i_rdata <= mem[o_raddr];
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Write scoreboard: every RAM write must match the next expected entry
    always @(negedge clk) begin
        if (o_wen) begin
            chk("wr_expected", {63'b0, wq.size() != 0}, 64'd1);
            if (wq.size() != 0) begin
                wexp = wq.pop_front();
                chk("wr_addr_data", {48'b0, o_waddr, o_wdata}, {48'b0, wexp});
            end
        end
    end

    task automatic do_read(input logic [5:0] r0, input logic [5:0] r1,
                           input logic [31:0] e0, input logic [31:0] e1, input bit poke);
        logic [31:0] a0, a1;
        logic [63:0] e;
        @(posedge clk); #1;
        i_rreq = 1'b1; i_rreg0 = r0; i_rreg1 = r1;
        rq.push_back({e1, e0});
        @(negedge clk);
        chk("rd_ren0", {63'b0, o_ren}, 64'd1);
        chk("rd_raddr0", {56'b0, o_raddr}, 64'(r0 * 4));
        @(posedge clk); #1;
        i_rreq = 1'b0;
        @(negedge clk);
        chk("rd_raddr1", {56'b0, o_raddr}, 64'(r1 * 4));
        chk("rd_ready_early", {63'b0, o_ready}, 64'd0);
        @(negedge clk);
        chk("rd_ready", {63'b0, o_ready}, 64'd1);
        for (int i = 0; i < 32; i++) begin
            @(negedge clk);
            a0[i] = o_rdata0;
            a1[i] = o_rdata1;
            if (poke && i == 5) begin
                i_rreq = 1'b1; i_rreg0 = 6'd1;
            end
            if (poke && i == 6) i_rreq = 1'b0;
        end
        e = rq.pop_front();
        chk("rd_data0", {32'b0, a0}, {32'b0, e[31:0]});
        chk("rd_data1", {32'b0, a1}, {32'b0, e[63:32]});
        @(negedge clk);
        chk("rd_idle_zero", {60'b0, o_rdata0, o_rdata1, o_ready, o_ren}, 64'd0);
    endtask

    task automatic do_write(input logic [5:0] r0, input logic [31:0] d0, input bit e0,
                            input logic [5:0] r1, input logic [31:0] d1, input bit e1);
        for (int k = 0; k < 4; k++) begin
            if (e0) wq.push_back({8'(r0 * 4 + k), d0[8*k +: 8]});
            if (e1) wq.push_back({8'(r1 * 4 + k), d1[8*k +: 8]});
        end
        for (int i = 0; i < 32; i++) begin
            @(posedge clk); #1;
            i_wen0 = e0; i_wen1 = e1;
            i_wdata0 = d0[i]; i_wdata1 = d1[i];
            i_wreg0 = r0; i_wreg1 = r1;
        end
        @(posedge clk); #1;
        i_wen0 = 1'b0; i_wen1 = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("wr_drained", 64'(wq.size()), 64'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] v5, v10, wv, a0;
        i_rst = 1'b1; i_rreq = 1'b0; i_rreg0 = '0; i_rreg1 = '0;
        i_wreg0 = '0; i_wreg1 = '0; i_wen0 = 1'b0; i_wen1 = 1'b0;
        i_wdata0 = 1'b0; i_wdata1 = 1'b0;
        v5 = 32'hDEADBEEF; v10 = 32'h12345678;
        for (int a = 0; a < 144; a++) mem[a] = 8'h00;
        for (int k = 0; k < 4; k++) begin
            mem[20 + k] = v5[8*k +: 8];
            mem[40 + k] = v10[8*k +: 8];
            mem[k]      = 8'hFF;
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_outputs", {43'b0, o_rdata0, o_rdata1, o_ready, o_ren, o_wen, o_waddr, o_raddr}, 64'd0);
        @(posedge clk); #1;
        i_rst = 1'b0;

        // Basic two-register read
        do_read(6'd5, 6'd10, 32'hDEADBEEF, 32'h12345678, 1'b0);

        // Single-port write, then read it back while poking i_rreq mid-stream
        do_write(6'd3, 32'hA5A5A5A5, 1'b1, 6'd0, 32'h0, 1'b0);
        do_read(6'd3, 6'd5, 32'hA5A5A5A5, 32'hDEADBEEF, 1'b1);

        // Dual-port write into the CSR region
        do_write(6'd35, 32'h11223344, 1'b1, 6'd34, 32'h80000004, 1'b1);
        do_read(6'd35, 6'd34, 32'h11223344, 32'h80000004, 1'b0);

        // x0 reads as zero regardless of RAM content, on either port
        do_read(6'd0, 6'd10, 32'h0, 32'h12345678, 1'b0);
        do_read(6'd10, 6'd0, 32'h12345678, 32'h0, 1'b0);

        // Reset during a concurrent read and write at chunk 13
        wv = 32'h0F0F3C3C;
        wq.push_back({8'd28, wv[7:0]});
        @(posedge clk); #1;
        i_rreq = 1'b1; i_rreg0 = 6'd5; i_rreg1 = 6'd10;
        @(posedge clk); #1;
        i_rreq = 1'b0;
        @(posedge clk); #1;
        for (int i = 0; i < 13; i++) begin
            @(posedge clk); #1;
            i_wen0 = 1'b1; i_wdata0 = wv[i]; i_wreg0 = 6'd7;
            @(negedge clk);
            a0[i] = o_rdata0;
        end
        chk("rst_pre_bits", {51'b0, a0[12:0]}, {51'b0, 13'(v5)});
        @(posedge clk); #1;
        i_wdata0 = wv[13];
        i_rst = 1'b1;
        #1;
        chk("rst_async_zero", {43'b0, o_rdata0, o_rdata1, o_ready, o_ren, o_wen, o_waddr, o_raddr}, 64'd0);
        chk("rst_word0_written", 64'(wq.size()), 64'd0);
        i_wen0 = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        i_rst = 1'b0;
        @(negedge clk);
        chk("post_rst_no_wen", {63'b0, o_wen}, 64'd0);
        @(negedge clk);
        chk("post_rst_no_wen2", {63'b0, o_wen}, 64'd0);
        do_read(6'd5, 6'd10, 32'hDEADBEEF, 32'h12345678, 1'b0);

        chk("final_wq_empty", 64'(wq.size()), 64'd0);
        chk("final_rq_empty", 64'(rq.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
